// File: rtl/rm_decouple_pkg.sv
// Shared types and constants for the RM LED decoupler.
// Optional blink behaviour is selected by DECOUPLE_BLINK_EN in rm_led_decoupler.
package rm_decouple_pkg;

    typedef enum logic [1:0] {
        StPass,
        StHold,
        StRelease,
        StSettle
    } dec_state_e;

    localparam int unsigned DataWDefault = 16;
    localparam int unsigned ReconfCntW   = 8;
    localparam logic [ReconfCntW-1:0] ReconfCntMax = '1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Free-running divider: one-cycle tick every DIV cycles, restarted by a synchronous clear.
module blink_tick_gen #(
    parameter int unsigned DIV = 5_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = $clog2(DIV + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q + CntW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rm_led_decoupler.sv
// Static-region LED output stage that isolates the reconfigurable LED module during rewrite.
// Define DECOUPLE_BLINK_EN to blink the frozen pattern while the RM is isolated.
module rm_led_decoupler
    import rm_decouple_pkg::*;
#(
    parameter int unsigned DATA_W        = DataWDefault,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned BLINK_DIV     = 5_000_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [DATA_W-1:0]     rm_led,
    input  logic                  decouple_req,
    output logic                  decouple_ack,
    output logic                  rm_rst_n,
    output logic [DATA_W-1:0]     led,
    output logic [ReconfCntW-1:0] reconf_cnt
);

    localparam int unsigned CntW = $clog2(max_u(RST_CYCLES, SETTLE_CYCLES) + 1);
    localparam logic [CntW-1:0] RstLast    = CntW'(RST_CYCLES - 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

    dec_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]     pattern_q, pattern_d;
    logic [DATA_W-1:0]     led_q, led_d;
    logic                  ack_q, ack_d;
    logic                  rm_rst_n_q, rm_rst_n_d;
    logic                  armed_q, armed_d;
    logic [ReconfCntW-1:0] reconf_q, reconf_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        armed_d   = armed_q;
        reconf_d  = reconf_q;

        unique case (state_q)
            StPass: begin
                if (decouple_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end else begin
                    pattern_d = rm_led;
                end
            end
            StHold: begin
                if (!decouple_req) begin
                    state_d = StRelease;
                    cnt_d   = '0;
                end
            end
            StRelease: begin
                if (decouple_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end else if (cnt_q == RstLast) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSettle: begin
                if (decouple_req) begin
                    state_d = StHold;
                    cnt_d   = '0;
                    armed_d = 1'b1;
                end else if (cnt_q == SettleLast) begin
                    state_d = StPass;
                    cnt_d   = '0;
                    // Only a release that followed a real HOLD counts as a reconfiguration.
                    if (armed_q && (reconf_q != ReconfCntMax)) begin
                        reconf_d = reconf_q + ReconfCntW'(1);
                    end
                    armed_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StRelease;
                cnt_d   = '0;
            end
        endcase

        ack_d      = (state_d == StHold);
        rm_rst_n_d = (state_d == StPass) || (state_d == StSettle);
    end

`ifdef DECOUPLE_BLINK_EN
    logic blink_clr;
    logic blink_tick;
    logic vis_q, vis_d;

    assign blink_clr = (state_q == StPass);

    blink_tick_gen #(
        .DIV(BLINK_DIV)
    ) u_blink_tick_gen (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .clr      (blink_clr),
        .tick     (blink_tick)
    );

    // Phase restarts visible whenever PASS is left.
    always_comb begin
        vis_d = vis_q;
        if (state_q == StPass) begin
            vis_d = 1'b1;
        end else if (blink_tick) begin
            vis_d = ~vis_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            vis_q <= 1'b1;
        end else begin
            vis_q <= vis_d;
        end
    end

    assign led_d = ((state_d != StPass) && !vis_d) ? '0 : pattern_d;
`else
    assign led_d = pattern_d;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= StRelease;
            cnt_q      <= '0;
            pattern_q  <= '0;
            led_q      <= '0;
            ack_q      <= 1'b0;
            rm_rst_n_q <= 1'b0;
            armed_q    <= 1'b0;
            reconf_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pattern_q  <= pattern_d;
            led_q      <= led_d;
            ack_q      <= ack_d;
            rm_rst_n_q <= rm_rst_n_d;
            armed_q    <= armed_d;
            reconf_q   <= reconf_d;
        end
    end

    assign decouple_ack = ack_q;
    assign rm_rst_n     = rm_rst_n_q;
    assign led          = led_q;
    assign reconf_cnt   = reconf_q;

endmodule
